fp_add_share: RTL
=================

# fp_add_share

Shares one pipelined `fp_add` unit between `N_REQ` independent requesters.
- Arbitrates among pending requests and issues at most one operation per cycle into the adder.
- Tracks each in-flight operation's owner with a tag pipeline matched to adder latency, and routes each result back to its owner.
- Sits between FPU-using masters (CPU FPU port, accelerators) and a single `fp_add` instance, which it drives directly.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `LATENCY`, default 5: adder cycles from `fpu_start` to `fpu_done`, 1..16.
- `ID_W` (localparam): `$clog2(N_REQ)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `N_REQ`: request pending, one bit per requester.
- `req_ready`, out, `N_REQ`: request accepted this cycle (one-hot or zero).
- `req_op_a`, in, `N_REQ*32`: operand A; requester i uses bits [32i+:32].
- `req_op_b`, in, `N_REQ*32`: operand B, same packing.
- `rsp_valid`, out, `N_REQ`: one-cycle result pulse to the owner.
- `rsp_res`, out, 32: result, shared by all requesters; valid only with `rsp_valid`.
- `flush`, in, 1: discard all in-flight results.
- `busy`, out, 1: any operation in flight or issue pending.
- `err`, out, 1: sticky tag/done mismatch.
- `fpu_start`, out, 1: to adder `start`.
- `fpu_op_a`, `fpu_op_b`, out, 32: to adder operands.
- `fpu_done`, in, 1: from adder `done`.
- `fpu_res`, in, 32: from adder `res`.

## Operation
Request handshake:
- A requester holds `req_valid` and its operands stable until it sees `req_ready`.
- `req_ready` is combinational from `req_valid`, arbiter state and `flush`.
- `req_ready` is all-zero when `flush`=1 or `rst`=1.
- Accept (`req_valid[i] & req_ready[i]`) registers the operands into `fpu_op_a`/`fpu_op_b`, sets `fpu_start`=1 next cycle, and captures the requester id.

Arbitration and issue:
- Arbitration is round-robin or fixed priority (see Configuration).
- No backpressure from the adder: one accept is possible every cycle.

Tag pipeline:
- `LATENCY` entries of {valid, drop, id}.
- The cycle `fpu_start`=1 writes {1, 0, id} into entry 0; all entries shift by one each cycle.
- The tail entry aligns with the cycle `fpu_done` is expected.

Result delivery:
- `fpu_done`=1 with a valid, non-drop tail: next cycle `rsp_valid[id]`=1 and `rsp_res`=`fpu_res`.
- `fpu_done`=1 with a valid, drop tail: the result is discarded; no `rsp_valid`, no error.

Error detection:
- `fpu_done`=1 with an invalid tail, or a valid tail with `fpu_done`=0, sets `err`.
- `err` is cleared only by `rst`.
- Responses continue after an error.

Flush:
- Sets `drop` on every valid entry, including one being written that cycle.
- Blocks acceptance for that cycle.
- Operands already handshaken are not re-issued.

Other status:
- `busy` = any tail-pipeline entry valid, or `fpu_start` pending.

Reset:
- `rst` clears all tag entries and the arbiter pointer (to 0).
- Reset values: `fpu_start`=0, `fpu_op_a`=0, `fpu_op_b`=0, `rsp_valid`=0, `rsp_res`=0, `err`=0, `busy`=0, `req_ready`=0.
- The adder shares `rst`, so no stale `fpu_done` appears after reset mid-operation.

## Timing
Latency:
- Accept cycle T → `fpu_start` at T+1 → `fpu_done` at T+1+`LATENCY` → `rsp_valid` at T+2+`LATENCY`.
- With defaults the accept-to-response latency is 7 cycles.

Throughput and ordering:
- Throughput is 1 operation per cycle aggregate.
- A single requester held valid with no contention gets back-to-back accepts.
- Responses return in issue order; at most one `rsp_valid` bit is set per cycle.

Simultaneous events:
- Accept and response for the same requester in the same cycle are independent and both occur.
- `flush` coinciding with `fpu_done` drops that result.

## Configuration
Macro `FP_ADD_SHARE_RR_EN`.
- Defined: round-robin arbitration.
  - Priority starts at pointer p and searches upward, wrapping past `N_REQ-1` to 0.
  - On accept of requester i, p becomes (i+1) mod `N_REQ`.
  - A requester waits at most `N_REQ-1` accepts.
- Undefined: fixed priority; the lowest index with `req_valid` wins.
  - The pointer register is not generated.

## Test plan
1. Single op: req 0 sends `op_a`=0x3F800000, `op_b`=0x40000000 at cycle T → `fpu_start` at T+1; `rsp_valid`=0001 and `rsp_res`=0x40400000 at T+7; `busy` falls after.
2. Contention, `FP_ADD_SHARE_RR_EN` defined: all 4 requesters valid continuously → grants cycle 0,1,2,3,0…; each requester receives its own 1.0+i sums in order; no `err`.
3. Contention, macro undefined: req 0 and req 2 both held valid → only req 0 is accepted until it drops valid; req 2 is accepted the following cycle.
4. Flush: 3 ops in flight, `flush` pulsed → those 3 produce no `rsp_valid`; an op accepted after flush returns normally; `err`=0.
5. Error: force `fpu_done`=1 with the tag pipeline empty → `err`=1 next cycle and stays 1 until `rst`.
6. Reset mid-op: assert `rst` 3 cycles after an accept → no `rsp_valid` at any later cycle; all outputs at reset values; a new request after reset completes in 7 cycles.

Source files
------------

// File: rtl/fp_add_share.sv
// rtl/fp_add_share.sv - shares one pipelined fp_add between N_REQ requesters
// Define FP_ADD_SHARE_RR_EN for round-robin arbitration; default is fixed priority.
module fp_add_share #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_op_a,
  input  logic [N_REQ*32-1:0]  req_op_b,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_res,
  input  logic                 flush,
  output logic                 busy,
  output logic                 err,
  output logic                 fpu_start,
  output logic [31:0]          fpu_op_a,
  output logic [31:0]          fpu_op_b,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_res
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            accept;
  logic [ID_W-1:0] start_id;

  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_d;
  logic [ID_W-1:0]    tag_id [LATENCY];

  logic deliver;

`ifdef FP_ADD_SHARE_RR_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_idx;

  // Walk downward from the farthest slot so the one nearest rr_ptr is written last and wins.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    rr_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[rr_idx]) begin
        grant_any = 1'b1;
        grant_id  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(k);
      end
    end
  end
`endif

  assign accept = grant_any & ~flush & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_start <= 1'b0;
      fpu_op_a  <= '0;
      fpu_op_b  <= '0;
      start_id  <= '0;
    end else begin
      fpu_start <= accept;
      if (accept) begin
        fpu_op_a <= req_op_a[{grant_id, 5'd0} +: 32];
        fpu_op_b <= req_op_b[{grant_id, 5'd0} +: 32];
        start_id <= grant_id;
      end
    end
  end

  // Tag entry k holds the op started k+1 cycles ago; flush marks everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_d <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= fpu_start;
      tag_d[0]  <= flush;
      tag_id[0] <= start_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_d[k]  <= tag_d[k-1] | flush;
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign deliver = fpu_done & tag_v[LATENCY-1] & ~tag_d[LATENCY-1] & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_res   <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (deliver) begin
        rsp_valid[tag_id[LATENCY-1]] <= 1'b1;
        rsp_res                      <= fpu_res;
      end
      if (fpu_done != tag_v[LATENCY-1]) err <= 1'b1;
    end
  end

  assign busy = (|tag_v) | fpu_start;

endmodule
